alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Sequencer that sits in front of the combinational 36-bit ALU and drives it.
- Accepts one ALU command per valid/ready handshake and reads two source operands from an internal 8x36 register file.
- Presents the operands and opcode to the ALU, captures its result, carry-out and derived flags, and writes the result back to the destination register.
- Provides a host load port and a readback port for the register file.

Parameters:
NREGS, 8, register file depth; indices are 3 bits wide.
ZERO_R0, 1, when 1, register 0 always reads 0 and ignores writes.
OP_DIV, 5'd5, opcode value that is treated as divide, used for divide-by-zero detection.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  a command is presented this cycle.
cmd_ready  output  1  the block can accept a command; high only in IDLE.
cmd_op  input  5  ALU opcode.
cmd_rd  input  3  destination register index.
cmd_rs1  input  3  source register index for in1.
cmd_rs2  input  3  source register index for in2.
load_en  input  1  host write to the register file.
load_addr  input  3  host write index.
load_data  input  36  host write data.
rdbk_addr  input  3  readback index.
rdbk_data  output  36  combinational read of regs[rdbk_addr].
alu_in1  output  36  registered operand 1 to the ALU.
alu_in2  output  36  registered operand 2 to the ALU.
alu_op  output  5  registered opcode to the ALU.
alu_out  input  36  ALU result; combinational from alu_in1, alu_in2 and alu_op.
alu_cout  input  1  ALU carry/borrow out.
result  output  36  last captured result.
flags  output  4  [0] Z, [1] N, [2] C, [3] E (divide by zero).
done  output  1  one-cycle pulse while in WB.

Behaviour:
- Reset (asynchronous): FSM to IDLE; all registers, alu_in1, alu_in2, alu_op, result, flags cleared to 0; done=0. A command in flight is abandoned and no writeback occurs.
- FSM states are IDLE, READ, EXEC, WB; state advances one step per clock.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch op/rd/rs1/rs2 and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Register alu_in1 <= regs[rs1], alu_in2 <= regs[rs2], alu_op <= op.
  - Go to EXEC.
- EXEC:
  - The ALU settles during this cycle.
  - At the clock edge, result <= alu_out.
  - Z = (alu_out==0), N = alu_out[35], C = alu_cout.
  - E = (alu_op==OP_DIV && alu_in2==0).
  - When E=1, force Z=N=C=0.
  - Go to WB.
- WB:
  - done=1.
  - regs[rd] <= result at the clock edge, unless E=1, or rd==0 with ZERO_R0=1.
  - Go to IDLE.
- Latency and throughput:
  - Accept edge at t0; done is high during the cycle following the t2 edge.
  - Written data is visible on rdbk_data after the t3 edge.
  - One command every 4 cycles.
- cmd_valid outside IDLE is ignored; cmd_ready=0 there. Command fields need be stable only at the accept edge.
- load_en is honoured only in IDLE and is silently dropped in READ/EXEC/WB.
- Load and command accept in the same IDLE cycle: the load is written at that edge, and READ then sees the loaded value, including when load_addr==rs1 or rs2.
- rd equal to rs1 or rs2: READ uses the old value; the new value is written in WB.
- flags and result hold their values until the next EXEC capture. done is never asserted for two consecutive cycles.
- All arithmetic is done by the ALU. This block does not truncate or extend widths; carry comes only from alu_cout.

Test Plan:
- Load r1=36'd7, r2=36'd5 in IDLE; command op=ADD, rd=3, rs1=1, rs2=2 -> alu_in1=7 and alu_in2=5 after READ; done exactly 3 cycles after accept; r3=12; flags=4'b0000.
- r1=5, r2=7, op=SUB, rd=4 -> result=36'hF_FFFF_FFFE, flags N=1, C per alu_cout (1 with a borrow-producing ALU model); r4 written.
- r1=9, r2=0, op=OP_DIV, rd=5 with r5 preset to 36'd44 -> flags=4'b1000, r5 still 44, done still pulses.
- Same-cycle load r2=36'd3 and command ADD rd=0 rs1=2 rs2=2 with ZERO_R0=1 -> alu_in1=alu_in2=3, result=6, r0 reads 0; load_en asserted during EXEC is dropped.
- Assert rst during EXEC of ADD rd=6 -> immediate IDLE, cmd_ready=1, r6=0, done never pulses; a following command completes normally.
- Back-to-back cmd_valid held high for two commands -> second accepted exactly 4 cycles after the first; cmd_ready low in between.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Command sequencer in front of a combinational 36-bit ALU.
//             Accepts one command per valid/ready handshake. Reads two
//             operands from an internal 8x36 register file and presents them
//             to the ALU. Captures the result and flags, then writes the
//             result back to the destination register.
//  Ports    : clk, rst                    - clock, async active-high reset
//             cmd_valid/ready/op/rd/rs1/rs2 - command handshake and fields
//             load_en/addr/data           - host register-file write
//             rdbk_addr/rdbk_data         - combinational register readback
//             alu_in1/in2/op (out)        - registered ALU operands/opcode
//             alu_out/alu_cout (in)       - ALU result and carry/borrow
//             result, flags[3:0]={E,C,N,Z}, done (one-cycle WB pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int         NREGS   = 8,
  parameter bit         ZERO_R0 = 1'b1,
  parameter logic [4:0] OP_DIV  = 5'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic        load_en,
  input  logic [2:0]  load_addr,
  input  logic [35:0] load_data,
  input  logic [2:0]  rdbk_addr,
  output logic [35:0] rdbk_data,
  output logic [35:0] alu_in1,
  output logic [35:0] alu_in2,
  output logic [4:0]  alu_op,
  input  logic [35:0] alu_out,
  input  logic        alu_cout,
  output logic [35:0] result,
  output logic [3:0]  flags,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic [4:0]   r_op;
  logic [2:0]   r_rd;
  logic [2:0]   r_rs1;
  logic [2:0]   r_rs2;
  logic [35:0]  r_regs [NREGS];

  logic         w_accept;
  logic         w_load;
  logic         w_wb;
  logic         w_div0;
  logic [35:0]  w_rs1_data;
  logic [35:0]  w_rs2_data;

  // Register 0 may be hardwired to zero; every read path goes through here.
  function automatic logic [35:0] f_read(input logic [2:0] idx);
    if (ZERO_R0 && (idx == 3'd0)) begin
      f_read = '0;
    end else begin
      f_read = r_regs[idx];
    end
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next = S_READ;
        end
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ control terms
  always_comb begin
    w_accept   = cmd_valid && (r_state == S_IDLE);
    // Host loads only land while idle, so they never collide with writeback.
    w_load     = load_en && (r_state == S_IDLE);
    // A divide-by-zero result is never committed to the register file.
    w_wb       = (r_state == S_WB) && !flags[3] && !(ZERO_R0 && (r_rd == 3'd0));
    w_div0     = (alu_op == OP_DIV) && (alu_in2 == 36'd0);
    w_rs1_data = f_read(r_rs1);
    w_rs2_data = f_read(r_rs2);
    rdbk_data  = f_read(rdbk_addr);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
      result  <= '0;
      flags   <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_rd  <= cmd_rd;
        r_rs1 <= cmd_rs1;
        r_rs2 <= cmd_rs2;
      end
      // Operands are read one cycle after accept, so a same-cycle host load
      // to rs1/rs2 is already in the register file here.
      if (r_state == S_READ) begin
        alu_in1 <= w_rs1_data;
        alu_in2 <= w_rs2_data;
        alu_op  <= r_op;
      end
      if (r_state == S_EXEC) begin
        result <= alu_out;
        if (w_div0) begin
          flags <= 4'b1000;
        end else begin
          flags <= {1'b0, alu_cout, alu_out[35], (alu_out == 36'd0)};
        end
      end
    end
  end

  // ------------------------------------------------------ register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wb) begin
        r_regs[r_rd] <= result;
      end
      if (w_load && !(ZERO_R0 && (load_addr == 3'd0))) begin
        r_regs[load_addr] <= load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Self-checking bench for alu_issue with a behavioural ALU,
//             a register-file model and an expected-result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  localparam logic [4:0] C_OP_ADD = 5'd0;
  localparam logic [4:0] C_OP_SUB = 5'd1;
  localparam logic [4:0] C_OP_DIV = 5'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0;
  logic [2:0]  cmd_rs1 = '0;
  logic [2:0]  cmd_rs2 = '0;
  logic        load_en = 1'b0;
  logic [2:0]  load_addr = '0;
  logic [35:0] load_data = '0;
  logic [2:0]  rdbk_addr = '0;
  logic [35:0] rdbk_data;
  logic [35:0] alu_in1;
  logic [35:0] alu_in2;
  logic [4:0]  alu_op;
  logic [35:0] alu_out;
  logic        alu_cout;
  logic [35:0] result;
  logic [3:0]  flags;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [35:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb_q[$];

  logic [35:0] m_regs [8];
  bit          inject_exec_load = 1'b0;

  alu_issue #(.NREGS(8), .ZERO_R0(1'b1), .OP_DIV(5'd5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rdbk_addr(rdbk_addr), .rdbk_data(rdbk_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .result(result), .flags(flags), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carry/borrow, result}.
  function automatic logic [36:0] alu_f(input logic [4:0] op, input logic [35:0] a, input logic [35:0] b);
    case (op)
      C_OP_ADD: alu_f = {1'b0, a} + {1'b0, b};
      C_OP_SUB: alu_f = {1'b0, a} - {1'b0, b};
      C_OP_DIV: alu_f = (b == 36'd0) ? {1'b0, {36{1'b1}}} : {1'b0, a / b};
      default:  alu_f = {1'b0, a & b};
    endcase
  endfunction

  always_comb begin
    {alu_cout, alu_out} = alu_f(alu_op, alu_in1, alu_in2);
  end

  function automatic logic [3:0] flags_f(input logic [4:0] op, input logic [35:0] b, input logic [36:0] r);
    if (op == C_OP_DIV && b == 36'd0) flags_f = 4'b1000;
    else flags_f = {1'b0, r[36], r[35], (r[35:0] == 36'd0)};
  endfunction

  function automatic logic [35:0] m_rd(input logic [2:0] idx);
    m_rd = (idx == 3'd0) ? 36'd0 : m_regs[idx];
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", {35'd0, done}, 36'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_flags", {32'd0, flags}, {32'd0, e.flg});
      end
    end
  end

  // Compute expectation for a command, push it, and advance the model.
  task automatic push_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                          output logic [35:0] a, output logic [35:0] b);
    logic [36:0] r;
    exp_t e;
    a = m_rd(rs1);
    b = m_rd(rs2);
    r = alu_f(op, a, b);
    e.res = r[35:0];
    e.flg = flags_f(op, b, r);
    sb_q.push_back(e);
    if (!e.flg[3] && rd != 3'd0) m_regs[rd] = r[35:0];
  endtask

  task automatic check_reg(input logic [2:0] idx, input logic [35:0] exp);
    rdbk_addr = idx;
    #1;
    chk($sformatf("rdbk_r%0d", idx), rdbk_data, exp);
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [35:0] data);
    @(negedge clk);
    load_en = 1'b1; load_addr = addr; load_data = data;
    if (addr != 3'd0) m_regs[addr] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                         input bit ld, input logic [2:0] la, input logic [35:0] ldd);
    logic [35:0] a, b;
    @(negedge clk);
    chk("ready_idle", {35'd0, cmd_ready}, 36'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    if (ld) begin
      load_en = 1'b1; load_addr = la; load_data = ldd;
      if (la != 3'd0) m_regs[la] = ldd;
    end
    push_cmd(op, rd, rs1, rs2, a, b);
    @(negedge clk);  // READ
    cmd_valid = 1'b0; load_en = 1'b0;
    chk("ready_read", {35'd0, cmd_ready}, 36'd0);
    chk("done_read", {35'd0, done}, 36'd0);
    @(negedge clk);  // EXEC
    chk("alu_in1", alu_in1, a);
    chk("alu_in2", alu_in2, b);
    chk("alu_op", {31'd0, alu_op}, {31'd0, op});
    if (inject_exec_load) begin
      load_en = 1'b1; load_addr = 3'd7; load_data = 36'h123;
    end
    @(negedge clk);  // WB
    load_en = 1'b0;
    chk("done_wb", {35'd0, done}, 36'd1);
    @(negedge clk);  // IDLE
    chk("done_after", {35'd0, done}, 36'd0);
    check_reg(rd, m_rd(rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] a, b;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {35'd0, cmd_ready}, 36'd1);
    chk("rst_done", {35'd0, done}, 36'd0);
    chk("rst_result", result, 36'd0);
    chk("rst_flags", {32'd0, flags}, 36'd0);
    chk("rst_alu_in1", alu_in1, 36'd0);

    // ADD 7+5 -> r3
    do_load(3'd1, 36'd7);
    do_load(3'd2, 36'd5);
    run_cmd(C_OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 36'd0);
    check_reg(3'd3, 36'd12);

    // SUB 5-7 -> r4, negative with borrow
    do_load(3'd1, 36'd5);
    do_load(3'd2, 36'd7);
    run_cmd(C_OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 36'd0);
    chk("sub_result", result, 36'hF_FFFF_FFFE);
    chk("sub_flags", {32'd0, flags}, {32'd0, 4'b0110});

    // Divide by zero: no writeback
    do_load(3'd1, 36'd9);
    do_load(3'd2, 36'd0);
    do_load(3'd5, 36'd44);
    run_cmd(C_OP_DIV, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 36'd0);
    chk("div0_flags", {32'd0, flags}, {32'd0, 4'b1000});
    check_reg(3'd5, 36'd44);

    // Same-cycle load + command to r0; load during EXEC dropped
    do_load(3'd7, 36'd99);
    inject_exec_load = 1'b1;
    run_cmd(C_OP_ADD, 3'd0, 3'd2, 3'd2, 1'b1, 3'd2, 36'd3);
    inject_exec_load = 1'b0;
    chk("r0_result", result, 36'd6);
    check_reg(3'd0, 36'd0);
    check_reg(3'd7, 36'd99);

    // Reset during EXEC abandons the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_OP_ADD; cmd_rd = 3'd6; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_ready", {35'd0, cmd_ready}, 36'd1);
    chk("arst_result", result, 36'd0);
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_done", {35'd0, done}, 36'd0);
    end
    check_reg(3'd6, 36'd0);
    check_reg(3'd1, 36'd0);

    // A following command completes normally
    do_load(3'd1, 36'd10);
    do_load(3'd2, 36'd20);
    do_load(3'd6, 36'd30);
    run_cmd(C_OP_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 3'd0, 36'd0);

    // Back-to-back with cmd_valid held high
    @(negedge clk);
    chk("b2b_ready0", {35'd0, cmd_ready}, 36'd1);
    cmd_valid = 1'b1; cmd_op = C_OP_ADD; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    push_cmd(C_OP_ADD, 3'd7, 3'd1, 3'd2, a, b);
    @(negedge clk);
    cmd_op = C_OP_SUB; cmd_rd = 3'd1; cmd_rs1 = 3'd7; cmd_rs2 = 3'd6;
    chk("b2b_ready1", {35'd0, cmd_ready}, 36'd0);
    @(negedge clk);
    chk("b2b_ready2", {35'd0, cmd_ready}, 36'd0);
    @(negedge clk);
    chk("b2b_ready3", {35'd0, cmd_ready}, 36'd0);
    @(negedge clk);
    chk("b2b_ready4", {35'd0, cmd_ready}, 36'd1);
    push_cmd(C_OP_SUB, 3'd1, 3'd7, 3'd6, a, b);
    @(negedge clk);
    chk("b2b_accept2", {35'd0, cmd_ready}, 36'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_in1", alu_in1, a);
    chk("b2b_in2", alu_in2, b);
    @(negedge clk);
    chk("b2b_done", {35'd0, done}, 36'd1);
    @(negedge clk);
    chk("b2b_flags", {32'd0, flags}, {32'd0, 4'b0001});
    check_reg(3'd1, 36'd0);
    check_reg(3'd7, 36'd30);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 36'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
